// File: rtl/risk_pkg.sv
// Shared types and helpers for the multi-channel pre-trade risk gate.
package risk_pkg;

  localparam int RES_CODE_W = 2;
  // Wide enough to hold any WIDTH<=64 difference without wrapping.
  localparam int SAT_W      = 66;

  typedef enum logic [RES_CODE_W-1:0] {
    PASS        = 2'd0,
    FAIL_LIMIT  = 2'd1,
    FAIL_OVF    = 2'd2,
    FAIL_KILLED = 2'd3
  } res_code_e;

  // Signed subtraction clamped at zero; exposure is never driven negative by a cancel.
  function automatic logic signed [SAT_W-1:0] sat_sub(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b
  );
    logic signed [SAT_W-1:0] d;
    d = a - b;
    if (d[SAT_W-1]) begin
      return {SAT_W{1'b0}};
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/risk_ch_state.sv
// One channel's exposure/limit registers (plus fail counter and lock when
// RISK_KILL_SWITCH_EN is defined) and their commit logic.
module risk_ch_state
  import risk_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(32'd1000)
`ifdef RISK_KILL_SWITCH_EN
  , parameter int             KILL_THRESH   = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ord_hit,
  input  logic             ord_pass,
  input  logic [WIDTH-1:0] future,
  input  logic             cxl_hit,
  input  logic [WIDTH-1:0] cxl_amount,
  input  logic             cfg_hit,
  input  logic [WIDTH-1:0] cfg_limit,
`ifdef RISK_KILL_SWITCH_EN
  input  logic             ord_fail,
  output logic             lock_q,
`endif
  output logic [WIDTH-1:0] exp_q,
  output logic [WIDTH-1:0] lim_q
);

  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] lim_r;

  // Exposure and limit commit; a passing order already carries any same-channel cancel in future.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r <= {WIDTH{1'b0}};
      lim_r <= DEFAULT_LIMIT;
    end else begin
      if (ord_hit && ord_pass) begin
        exp_r <= future;
      end else if (cxl_hit) begin
        exp_r <= WIDTH'(sat_sub(SAT_W'($signed(exp_r)), SAT_W'($signed(cxl_amount))));
      end else begin
        exp_r <= exp_r;
      end
      if (cfg_hit) begin
        lim_r <= cfg_limit;
      end else begin
        lim_r <= lim_r;
      end
    end
  end

  assign exp_q = exp_r;
  assign lim_q = lim_r;

`ifdef RISK_KILL_SWITCH_EN
  localparam int CNT_W = $clog2(KILL_THRESH + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             lock_r;

  // Consecutive-fail tracking; a limit write on the same cycle wins over an order's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      lock_r <= 1'b0;
    end else if (cfg_hit) begin
      cnt_r  <= {CNT_W{1'b0}};
      lock_r <= 1'b0;
    end else if (ord_hit && ord_fail) begin
      if (cnt_r < CNT_W'(KILL_THRESH)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (cnt_r >= CNT_W'(KILL_THRESH - 1)) begin
        lock_r <= 1'b1;
      end else begin
        lock_r <= lock_r;
      end
    end else if (ord_hit && ord_pass) begin
      cnt_r  <= {CNT_W{1'b0}};
      lock_r <= lock_r;
    end else begin
      cnt_r  <= cnt_r;
      lock_r <= lock_r;
    end
  end

  assign lock_q = lock_r;
`endif

endmodule

// File: rtl/risk_check_mc.sv
// Clocked multi-channel pre-trade risk gate with a single-entry verdict register.
// Optional consecutive-fail kill switch enabled by defining RISK_KILL_SWITCH_EN.
module risk_check_mc
  import risk_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               NUM_CH        = 4,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(32'd1000),
`ifdef RISK_KILL_SWITCH_EN
  parameter int               KILL_THRESH   = 3,
`endif
  localparam int              CH_W          = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ord_valid,
  output logic                  ord_ready,
  input  logic [CH_W-1:0]       ord_ch,
  input  logic [WIDTH-1:0]      ord_amount,
  input  logic                  cxl_valid,
  input  logic [CH_W-1:0]       cxl_ch,
  input  logic [WIDTH-1:0]      cxl_amount,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]      cfg_limit,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CH_W-1:0]       res_ch,
  output logic [RES_CODE_W-1:0] res_code,
  output logic                  res_fail
);

  // One guard bit beyond WIDTH+1 so exp + amount - cancel can never wrap.
  localparam int FW = WIDTH + 2;
  localparam logic signed [FW-1:0] F_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] F_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]       exp_all_s [NUM_CH];
  logic [WIDTH-1:0]       lim_all_s [NUM_CH];
  logic [WIDTH-1:0]       exp_sel_s;
  logic [WIDTH-1:0]       lim_sel_s;
  logic                   lock_sel_s;
  logic                   accept_s;
  logic                   cxl_same_s;
  logic                   ovf_s;
  logic                   over_lim_s;
  logic signed [FW-1:0]   future_s;
  res_code_e              code_s;
`ifdef RISK_KILL_SWITCH_EN
  logic [NUM_CH-1:0]      lock_all_s;
`endif

  assign ord_ready  = !res_valid || res_ready;
  assign accept_s   = ord_valid && ord_ready;
  assign cxl_same_s = cxl_valid && (cxl_ch == ord_ch);

  // AND-OR channel mux selecting the ordered channel's state.
  always_comb begin
    exp_sel_s  = {WIDTH{1'b0}};
    lim_sel_s  = {WIDTH{1'b0}};
    lock_sel_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_sel_s = exp_sel_s | ({WIDTH{ord_ch == CH_W'(i)}} & exp_all_s[i]);
      lim_sel_s = lim_sel_s | ({WIDTH{ord_ch == CH_W'(i)}} & lim_all_s[i]);
`ifdef RISK_KILL_SWITCH_EN
      lock_sel_s = lock_sel_s | ((ord_ch == CH_W'(i)) && lock_all_s[i]);
`endif
    end
  end

  // Projected exposure and verdict; the limit used is the pre-write value.
  always_comb begin
    future_s   = FW'($signed(exp_sel_s)) + FW'($signed(ord_amount))
               - (cxl_same_s ? FW'($signed(cxl_amount)) : {FW{1'b0}});
    ovf_s      = (future_s > F_MAX) || (future_s < F_MIN);
    over_lim_s = FW'($signed(lim_sel_s)) < future_s;
    if (lock_sel_s) begin
      code_s = FAIL_KILLED;
    end else if (ovf_s) begin
      code_s = FAIL_OVF;
    end else if (over_lim_s) begin
      code_s = FAIL_LIMIT;
    end else begin
      code_s = PASS;
    end
  end

  // Verdict register: loads on accept, clears when consumed, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_ch    <= {CH_W{1'b0}};
      res_code  <= PASS;
      res_fail  <= 1'b0;
    end else if (accept_s) begin
      res_valid <= 1'b1;
      res_ch    <= ord_ch;
      res_code  <= code_s;
      res_fail  <= (code_s != PASS);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    risk_ch_state #(
      .WIDTH         (WIDTH),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
`ifdef RISK_KILL_SWITCH_EN
      , .KILL_THRESH (KILL_THRESH)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ord_hit    (accept_s && (ord_ch == CH_W'(g))),
      .ord_pass   (code_s == PASS),
      .future     (future_s[WIDTH-1:0]),
      .cxl_hit    (cxl_valid && (cxl_ch == CH_W'(g))),
      .cxl_amount (cxl_amount),
      .cfg_hit    (cfg_we && (cfg_ch == CH_W'(g))),
      .cfg_limit  (cfg_limit),
`ifdef RISK_KILL_SWITCH_EN
      .ord_fail   ((code_s == FAIL_LIMIT) || (code_s == FAIL_OVF)),
      .lock_q     (lock_all_s[g]),
`endif
      .exp_q      (exp_all_s[g]),
      .lim_q      (lim_all_s[g])
    );
  end

endmodule

// File: tb/tb_risk_check_mc.sv
// Randomized and directed bench for risk_check_mc against an arithmetic reference model.
module tb_risk_check_mc;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int KT     = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            rst;
  logic            ord_valid, ord_ready;
  logic [CH_W-1:0] ord_ch;
  logic [31:0]     ord_amount;
  logic            cxl_valid;
  logic [CH_W-1:0] cxl_ch;
  logic [31:0]     cxl_amount;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [31:0]     cfg_limit;
  logic            res_valid, res_ready, res_fail;
  logic [CH_W-1:0] res_ch;
  logic [1:0]      res_code;

  always #5 clk = ~clk;

  risk_check_mc dut (
    .clk(clk), .rst(rst),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_ch(ord_ch), .ord_amount(ord_amount),
    .cxl_valid(cxl_valid), .cxl_ch(cxl_ch), .cxl_amount(cxl_amount),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_limit(cfg_limit),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_code(res_code), .res_fail(res_fail)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: exposures, limits, fail streaks, locks and the expected verdict register.
  longint m_exp [NUM_CH];
  longint m_lim [NUM_CH];
  int     m_cnt [NUM_CH];
  bit     m_lock[NUM_CH];
  bit     m_valid;
  int     m_ch;
  int     m_code;

  task automatic check_val(string tag, longint obs, longint exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint sx(logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clamp0(longint v);
    return (v < 0) ? 64'sd0 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_exp[i] = 0; m_lim[i] = 1000; m_cnt[i] = 0; m_lock[i] = 1'b0;
    end
    m_valid = 1'b0; m_ch = 0; m_code = 0;
  endtask

  // One clock: predict from current inputs, advance the model, then compare all outputs.
  task automatic step();
    bit rdy, acc, same;
    longint fut;
    int code, oc, cc;
    @(negedge clk);
    rdy = !m_valid || res_ready;
    check_val("ord_ready", ord_ready, rdy);
    if (rst) begin
      model_reset();
    end else begin
      oc   = int'(ord_ch);
      cc   = int'(cxl_ch);
      acc  = ord_valid && rdy;
      same = cxl_valid && (cxl_ch == ord_ch);
      fut  = m_exp[oc] + sx(ord_amount) - (same ? sx(cxl_amount) : 64'sd0);
      if (m_lock[oc]) code = 3;
      else if (fut > SMAX || fut < SMIN) code = 2;
      else if (m_lim[oc] < fut) code = 1;
      else code = 0;
      if (acc) begin
        if (code == 0) m_exp[oc] = fut;
        else if (same) m_exp[oc] = clamp0(m_exp[oc] - sx(cxl_amount));
`ifdef RISK_KILL_SWITCH_EN
        if (code == 1 || code == 2) begin
          if (m_cnt[oc] < KT) m_cnt[oc]++;
          if (m_cnt[oc] >= KT) m_lock[oc] = 1'b1;
        end else if (code == 0) begin
          m_cnt[oc] = 0;
        end
`endif
        m_valid = 1'b1; m_ch = oc; m_code = code;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
      if (cxl_valid && !(acc && same)) m_exp[cc] = clamp0(m_exp[cc] - sx(cxl_amount));
      if (cfg_we) begin
        m_lim[int'(cfg_ch)]  = sx(cfg_limit);
        m_cnt[int'(cfg_ch)]  = 0;
        m_lock[int'(cfg_ch)] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_val("res_valid", res_valid, m_valid);
    check_val("res_ch", res_ch, m_ch);
    check_val("res_code", res_code, m_code);
    check_val("res_fail", res_fail, (m_code != 0));
  endtask

  task automatic idle_inputs();
    ord_valid = 1'b0; ord_ch = '0; ord_amount = 32'd0;
    cxl_valid = 1'b0; cxl_ch = '0; cxl_amount = 32'd0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_limit = 32'd0;
  endtask

  task automatic order(int ch, logic [31:0] amt);
    ord_valid = 1'b1; ord_ch = CH_W'(ch); ord_amount = amt;
    step();
    idle_inputs();
  endtask

  task automatic order_cxl(int ch, logic [31:0] amt, int cch, logic [31:0] camt);
    cxl_valid = 1'b1; cxl_ch = CH_W'(cch); cxl_amount = camt;
    order(ch, amt);
  endtask

  task automatic cancel(int ch, logic [31:0] amt);
    cxl_valid = 1'b1; cxl_ch = CH_W'(ch); cxl_amount = amt;
    step();
    idle_inputs();
  endtask

  task automatic cfg(int ch, logic [31:0] lim);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_limit = lim;
    step();
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    res_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    check_val("rst_valid", res_valid, 0);
    check_val("rst_code", res_code, 0);
    check_val("rst_fail", res_fail, 0);
    check_val("rst_ch", res_ch, 0);
    rst = 1'b0;

    // Limit boundary on ch0.
    order(0, 32'd1000);
    check_val("t1_pass", res_code, 0);
    order(0, 32'd1);
    check_val("t1_limit", res_code, 1);
    check_val("t1_limit_fail", res_fail, 1);
    order(0, 32'd0);
    check_val("t1_exp_kept", res_code, 0);

    // Same-cycle cancel folded into the projection on ch1.
    order(1, 32'd900);
    order_cxl(1, 32'd200, 1, 32'd100);
    check_val("t2_pass_cxl", res_code, 0);
    order(1, 32'd1);
    check_val("t2_at_limit", res_code, 1);

    // Overflow and clamping on ch2.
    cfg(2, 32'h7FFF_FFFF);
    order(2, 32'h7FFF_FFFF);
    check_val("t3_max_pass", res_code, 0);
    order(2, 32'd1);
    check_val("t3_ovf", res_code, 2);
    cancel(2, 32'h7FFF_FFFF);
    order(2, 32'd100);
    cancel(2, 32'h7FFF_FFFF);
    order(2, 32'h7FFF_FFFF);
    order(2, 32'd1);
    check_val("t3_clamp_ovf", res_code, 2);

    // Cross-channel cancel alongside an order.
    order_cxl(0, 32'd0, 1, 32'd500);
    order(1, 32'd500);
    check_val("t3_cross_cxl", res_code, 0);

    // Backpressure hold, release, and reset during a hold.
    res_ready = 1'b0;
    ord_valid = 1'b1; ord_ch = CH_W'(3); ord_amount = 32'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t4_held_ready", ord_ready, 0);
    end
    res_ready = 1'b1;
    step();
    check_val("t4_release_valid", res_valid, 1);
    check_val("t4_release_ch", res_ch, 3);
    res_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_val("t4_rst_valid", res_valid, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    idle_inputs();
    step();

    // Kill switch on ch3.
    for (int i = 0; i < KT; i++) begin
      order(3, 32'd2000);
      check_val("t5_streak", res_code, 1);
    end
    order(3, 32'd0);
`ifdef RISK_KILL_SWITCH_EN
    check_val("t5_killed", res_code, 3);
`else
    check_val("t5_no_kill", res_code, 0);
`endif
    cfg(3, 32'd1000);
    order(3, 32'd0);
    check_val("t5_unlocked", res_code, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      res_ready  = ($urandom_range(0, 3) != 0);
      ord_valid  = ($urandom_range(0, 2) != 0);
      ord_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      ord_amount = ($urandom_range(0, 19) == 0) ? 32'h7FFF_FF00 + 32'($urandom_range(0, 255))
                                                : 32'($urandom_range(0, 600));
      cxl_valid  = ($urandom_range(0, 2) == 0);
      cxl_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      cxl_amount = ($urandom_range(0, 29) == 0) ? 32'h7FFF_FFFF : 32'($urandom_range(0, 400));
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      case ($urandom_range(0, 3))
        0:       cfg_limit = 32'h7FFF_FFFF;
        1:       cfg_limit = 32'hFFFF_FF00;
        default: cfg_limit = 32'($urandom_range(0, 3000));
      endcase
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
